pipe_elastic_buffer: RTL and testbench

PIPE_ELASTIC_BUFFER -- requirements
Module: pipe_elastic_buffer

---
 rtl/pipe_elastic_buffer.sv | 83 ++++++++
 tb/tb_pipe_elastic_buffer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_elastic_buffer.sv
// Elastic FIFO buffer between two pipeline stages: registered ready/valid,
// synchronous flush for redirects, and a saturating back-pressure counter.
module pipe_elastic_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [CW-1:0]    occupancy,
  output logic [15:0]      stall_cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [15:0]      stall_q, stall_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push, pop;

  // Handshake outputs depend only on registered state.
  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign occupancy = count_q;
  assign stall_cnt = stall_q;
  // Gate the read so an empty buffer always shows a known, stable value.
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    push     = in_valid && in_ready && !flush;
    pop      = out_valid && out_ready && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    stall_d  = stall_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    // Back-pressure is counted independently of flush handling above.
    if (in_valid && !in_ready && !flush && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_pipe_elastic_buffer.sv
// Testbench for pipe_elastic_buffer (WIDTH=32, DEPTH=4): directed vector table,
// hand-written corner sequences and random traffic against a queue model.
module tb_pipe_elastic_buffer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             flush;
  logic [CW-1:0]    occupancy;
  logic [15:0]      stall_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] mq[$];
  int          m_stall = 0;

  typedef struct {
    logic        v;
    logic        r;
    logic        f;
    logic [31:0] d;
    int          occ;
    logic        ov;
    logic [31:0] od;
    logic        ir;
    int          stall;
  } vec_t;

  vec_t tbl[14];

  pipe_elastic_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic v, logic r, logic f, logic [31:0] d,
                              int occ, logic ov, logic [31:0] od, logic ir, int st);
    vec_t x;
    x.v = v; x.r = r; x.f = f; x.d = d;
    x.occ = occ; x.ov = ov; x.od = od; x.ir = ir; x.stall = st;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: a queue of accepted words plus a saturating stall counter.
  task automatic tick();
    bit do_push, do_pop;
    if (reset) begin
      if (flush) begin
        mq.delete();
      end else begin
        do_pop  = (mq.size() > 0) && out_ready;
        do_push = in_valid && (mq.size() < DEPTH);
        if (in_valid && mq.size() == DEPTH && m_stall < 65535) m_stall++;
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back(in_data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string name);
    chk({name, ".occ"},   32'(occupancy), 32'(mq.size()));
    chk({name, ".ovld"},  32'(out_valid), 32'(mq.size() > 0));
    chk({name, ".irdy"},  32'(in_ready),  32'(mq.size() < DEPTH));
    chk({name, ".stall"}, 32'(stall_cnt), 32'(m_stall));
    if (mq.size() > 0) chk({name, ".odata"}, out_data, mq[0]);
  endtask

  task automatic async_reset_pulse();
    #2 reset = 1'b0;
    mq.delete();
    m_stall = 0;
    #1;
    chk("async_rst.ovld",  32'(out_valid), 32'd0);
    chk("async_rst.occ",   32'(occupancy), 32'd0);
    chk("async_rst.irdy",  32'(in_ready),  32'd1);
    chk("async_rst.stall", 32'(stall_cnt), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_data = '0;
    #1;
    chk("reset.ovld",  32'(out_valid), 32'd0);
    chk("reset.irdy",  32'(in_ready),  32'd1);
    chk("reset.occ",   32'(occupancy), 32'd0);
    chk("reset.stall", 32'(stall_cnt), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;

    //            v     r     f     data          occ ov    od            ir    stall
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 32'hA0000001, 1, 1'b1, 32'hA0000001, 1'b1, 0);
    tbl[1]  = mk(1'b1, 1'b0, 1'b0, 32'h2,        2, 1'b1, 32'hA0000001, 1'b1, 0);
    tbl[2]  = mk(1'b1, 1'b0, 1'b0, 32'h3,        3, 1'b1, 32'hA0000001, 1'b1, 0);
    tbl[3]  = mk(1'b1, 1'b0, 1'b0, 32'h4,        4, 1'b1, 32'hA0000001, 1'b0, 0);
    tbl[4]  = mk(1'b1, 1'b0, 1'b0, 32'h5,        4, 1'b1, 32'hA0000001, 1'b0, 1);
    tbl[5]  = mk(1'b0, 1'b1, 1'b0, 32'h0,        3, 1'b1, 32'h2,        1'b1, 1);
    tbl[6]  = mk(1'b0, 1'b1, 1'b0, 32'h0,        2, 1'b1, 32'h3,        1'b1, 1);
    tbl[7]  = mk(1'b1, 1'b1, 1'b0, 32'h6,        2, 1'b1, 32'h4,        1'b1, 1);
    tbl[8]  = mk(1'b0, 1'b1, 1'b0, 32'h0,        1, 1'b1, 32'h6,        1'b1, 1);
    tbl[9]  = mk(1'b1, 1'b0, 1'b0, 32'h7,        2, 1'b1, 32'h6,        1'b1, 1);
    tbl[10] = mk(1'b1, 1'b0, 1'b0, 32'h8,        3, 1'b1, 32'h6,        1'b1, 1);
    tbl[11] = mk(1'b1, 1'b1, 1'b1, 32'h9,        0, 1'b0, 32'h0,        1'b1, 1);
    tbl[12] = mk(1'b1, 1'b0, 1'b0, 32'hA,        1, 1'b1, 32'hA,        1'b1, 1);
    tbl[13] = mk(1'b0, 1'b1, 1'b0, 32'h0,        0, 1'b0, 32'h0,        1'b1, 1);

    for (int i = 0; i < 14; i++) begin
      in_valid = tbl[i].v; out_ready = tbl[i].r; flush = tbl[i].f; in_data = tbl[i].d;
      tick();
      chk($sformatf("vec%0d.occ", i),   32'(occupancy), 32'(tbl[i].occ));
      chk($sformatf("vec%0d.ovld", i),  32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("vec%0d.irdy", i),  32'(in_ready),  32'(tbl[i].ir));
      chk($sformatf("vec%0d.stall", i), 32'(stall_cnt), 32'(tbl[i].stall));
      if (tbl[i].ov) chk($sformatf("vec%0d.odata", i), out_data, tbl[i].od);
    end

    // Streaming through a single-entry steady state across pointer wrap.
    in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_data = 32'h100 + 32'(i);
      tick();
      chk($sformatf("stream%0d.occ", i),   32'(occupancy), 32'd1);
      chk($sformatf("stream%0d.odata", i), out_data, 32'h100 + 32'(i));
    end
    in_valid = 1'b0;
    tick();
    check_model("stream_end");

    // Flush while three entries are held and a push is offered.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'h200 + 32'(i);
      tick();
    end
    chk("pre_flush.occ", 32'(occupancy), 32'd3);
    flush = 1'b1; in_data = 32'hDEAD;
    tick();
    flush = 1'b0;
    chk("flush.occ",  32'(occupancy), 32'd0);
    chk("flush.ovld", 32'(out_valid), 32'd0);
    chk("flush.irdy", 32'(in_ready),  32'd1);
    in_valid = 1'b0;
    tick();
    chk("flush_after.ovld", 32'(out_valid), 32'd0);

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush     = 1'($urandom_range(0, 15) == 0);
      in_data   = $urandom;
      tick();
      check_model($sformatf("rand%0d", i));
    end
    flush = 1'b0;

    // Reset between edges while two words are held.
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    while (mq.size() > 0) begin out_ready = 1'b1; tick(); end
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'h301; tick();
    in_data = 32'h302; tick();
    in_valid = 1'b0;
    chk("pre_rst.occ", 32'(occupancy), 32'd2);
    async_reset_pulse();
    in_valid = 1'b1; in_data = 32'h3A5;
    tick();
    in_valid = 1'b0;
    chk("post_rst.odata", out_data, 32'h3A5);
    check_model("post_rst");

    // Stall counter saturation with the buffer held full.
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 65545; i++) begin
      in_data = $urandom;
      tick();
    end
    chk("sat.stall", 32'(stall_cnt), 32'hFFFF);
    check_model("sat");
    tick(); tick();
    chk("sat_hold.stall", 32'(stall_cnt), 32'hFFFF);
    async_reset_pulse();
    in_valid = 1'b0;
    tick();
    check_model("sat_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
